seven_segment_scanner: RTL and testbench

- Display-side driver for the team's seven-segment boards: takes a hex word from the CPU datapath (PC, register, ALU result) and time-multiplexes it across a common-anode digit bank.
- Owns nibble-to-segment encoding, digit refresh counter, tear-free frame-synchronous load, and per-digit decimal points.
- Sits between debug/display mux and board pins.

---
 rtl/seven_segment_scanner_if.sv | 24 ++
 rtl/seven_segment_scanner.sv | 138 +++++++++++++
 tb/tb_seven_segment_scanner.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_scanner_if.sv
// Display bus for seven_segment_scanner. The host side (master) drives the hex word,
// the dp requests, load and enable. The scanner (slave) drives the board pins.
interface seven_segment_scanner_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic                load;
  logic                enable;
  logic [6:0]          seg;
  logic                dp_n;
  logic [DIGITS-1:0]   an;
  logic                frame_done;

  modport master (
    output data, dp, load, enable,
    input  seg, dp_n, an, frame_done
  );

  modport slave (
    input  data, dp, load, enable,
    output seg, dp_n, an, frame_done
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode hex display driver with a frame-synchronous shadow load.
// Optional macro LEADING_ZERO_BLANK_EN blanks the digits above the most-significant non-zero nibble.
module seven_segment_scanner #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 50000
) (
  input logic                  clock,
  input logic                  clear,
  seven_segment_scanner_if.slave bus
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]       prescaler;
  logic [IW-1:0]       index;
  logic [4*DIGITS-1:0] staged_data, shadow_data;
  logic [DIGITS-1:0]   staged_dp, shadow_dp;
  logic                pending;
  logic                tick, boundary;
  logic [3:0]          nib;
  logic                cur_dp;
  logic                shown;
  logic [DIGITS-1:0]   an_next;

  function automatic logic [6:0] encode(input logic [3:0] n);
    case (n)
      4'h0: encode = 7'b0000001;
      4'h1: encode = 7'b1001111;
      4'h2: encode = 7'b0010010;
      4'h3: encode = 7'b0000110;
      4'h4: encode = 7'b1001100;
      4'h5: encode = 7'b0100100;
      4'h6: encode = 7'b0100000;
      4'h7: encode = 7'b0001111;
      4'h8: encode = 7'b0000000;
      4'h9: encode = 7'b0000100;
      4'hA: encode = 7'b0001000;
      4'hB: encode = 7'b1100000;
      4'hC: encode = 7'b0110001;
      4'hD: encode = 7'b1000010;
      4'hE: encode = 7'b0110000;
      default: encode = 7'b0111000;
    endcase
  endfunction

  assign tick     = bus.enable && (prescaler == PRE_LAST);
  assign boundary = tick && (index == IDX_LAST);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      prescaler <= '0;
      index     <= '0;
    end else if (bus.enable) begin
      if (tick) begin
        prescaler <= '0;
        index     <= boundary ? '0 : index + IW'(1);
      end else begin
        prescaler <= prescaler + PW'(1);
      end
    end
  end

  // A load on the boundary cycle bypasses staging so the newest value is never lost.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      staged_data <= '0;
      staged_dp   <= '0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      pending     <= 1'b0;
    end else begin
      if (bus.load) begin
        staged_data <= bus.data;
        staged_dp   <= bus.dp;
      end
      if (boundary) begin
        pending <= 1'b0;
        if (bus.load) begin
          shadow_data <= bus.data;
          shadow_dp   <= bus.dp;
        end else if (pending) begin
          shadow_data <= staged_data;
          shadow_dp   <= staged_dp;
        end
      end else if (bus.load) begin
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    nib     = '0;
    cur_dp  = 1'b0;
    an_next = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (index == IW'(i)) begin
        nib        = shadow_data[i*4 +: 4];
        cur_dp     = shadow_dp[i];
        an_next[i] = 1'b0;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msd;
  always_comb begin
    msd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (shadow_data[i*4 +: 4] != 4'h0) msd = IW'(i);
    end
  end
  assign shown = (index <= msd);
`else
  assign shown = 1'b1;
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      bus.seg        <= 7'h7F;
      bus.dp_n       <= 1'b1;
      bus.an         <= '1;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= boundary;
      if (!bus.enable || !shown) begin
        bus.seg  <= 7'h7F;
        bus.dp_n <= 1'b1;
        bus.an   <= '1;
      end else begin
        bus.seg  <= encode(nib);
        bus.dp_n <= ~cur_dp;
        bus.an   <= an_next;
      end
    end
  end
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner (DIGITS=8, REFRESH_DIV=4) with a per-cycle expectation queue.
module tb_seven_segment_scanner;
  localparam int DIGITS = 8;
  localparam int RDIV   = 4;
  localparam int FRAME  = DIGITS * RDIV;

  logic clock;
  logic clear;
  seven_segment_scanner_if #(.DIGITS(DIGITS)) bus ();

  seven_segment_scanner #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV)) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_q[$];

  // Spec-side reference state: scan position within the frame plus the visible and staged words.
  int          pos;
  logic [31:0] sh_v, st_v;
  logic [7:0]  sh_p, st_p;
  logic        pend;

  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111; seg_tab[2]  = 7'b0010010; seg_tab[3]  = 7'b0000110;
    seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100; seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0000100; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
    seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010; seg_tab[14] = 7'b0110000; seg_tab[15] = 7'b0111000;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] predict(input logic en);
    int          d;
    int          msd;
    logic [7:0]  an_e;
    logic        fd;
    if (!en) return {1'b0, 8'hFF, 7'h7F, 1'b1};
    fd  = (pos % FRAME) == FRAME - 1;
    d   = (pos % FRAME) / RDIV;
    msd = 0;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 0; i < DIGITS; i++) if (sh_v[i*4 +: 4] != 4'h0) msd = i;
`else
    msd = DIGITS - 1;
`endif
    if (d > msd) return {fd, 8'hFF, 7'h7F, 1'b1};
    an_e    = 8'hFF;
    an_e[d] = 1'b0;
    return {fd, an_e, seg_tab[sh_v[d*4 +: 4]], ~sh_p[d]};
  endfunction

  task automatic model_reset();
    pos = 0; sh_v = '0; st_v = '0; sh_p = '0; st_p = '0; pend = 1'b0;
    exp_q.delete();
  endtask

  // Called at a negedge: drive inputs, push the expectation for the coming edge, then compare.
  task automatic step(input logic en, input logic ld, input logic [31:0] d, input logic [7:0] p);
    logic [16:0] e;
    logic [16:0] o;
    logic        bnd;
    bus.enable = en;
    bus.load   = ld;
    bus.data   = d;
    bus.dp     = p;
    exp_q.push_back(predict(en));
    bnd = en && ((pos % FRAME) == FRAME - 1);
    if (bnd) begin
      if (ld) begin sh_v = d; sh_p = p; end
      else if (pend) begin sh_v = st_v; sh_p = st_p; end
      pend = 1'b0;
    end else if (ld) begin
      pend = 1'b1;
    end
    if (ld) begin st_v = d; st_p = p; end
    if (en) pos = (pos + 1) % FRAME;
    @(posedge clock);
    @(negedge clock);
    o = {bus.frame_done, bus.an, bus.seg, bus.dp_n};
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("scan_out", {15'd0, o}, {15'd0, e});
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, bus.data, bus.dp);
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 2 * FRAME && (pos % FRAME) != target; i++) step(1'b1, 1'b0, bus.data, bus.dp);
  endtask

  task automatic async_reset();
    #2;
    clear      = 1'b1;
    bus.enable = 1'b0;
    bus.load   = 1'b0;
    #1;
    check("rst_seg", {25'd0, bus.seg}, 32'h7F);
    check("rst_an", {24'd0, bus.an}, 32'hFF);
    check("rst_dp_n", {31'd0, bus.dp_n}, 32'd1);
    check("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
    @(negedge clock);
    #1 clear = 1'b0;
    model_reset();
    @(negedge clock);
  endtask

  initial begin
    clear      = 1'b1;
    bus.data   = '0;
    bus.dp     = '0;
    bus.load   = 1'b0;
    bus.enable = 1'b0;
    model_reset();
    @(negedge clock);
    check("init_seg", {25'd0, bus.seg}, 32'h7F);
    check("init_an", {24'd0, bus.an}, 32'hFF);
    @(negedge clock);
    #1 clear = 1'b0;
    @(negedge clock);

    // first lit digit after reset is digit 0 showing "0"
    run(6);

    // scan order with a loaded word and dp on digit 0
    step(1'b1, 1'b1, 32'h89ABCDEF, 8'h01);
    run(2 * FRAME + 3);

    // tear-free load: two loads in one frame, only the last reaches the display
    run_to(5);
    step(1'b1, 1'b1, 32'h11111111, 8'h00);
    run(10);
    step(1'b1, 1'b1, 32'h22222222, 8'h00);
    run_to(0);
    run(FRAME + 2);

    // load on the boundary cycle itself, then a frame with nothing pending
    run_to(FRAME - 1);
    step(1'b1, 1'b1, 32'h00000007, 8'h80);
    run(2 * FRAME);

    // enable dropped mid-digit 3, load while disabled, resume from held position
    run_to(3 * RDIV + 2);
    for (int i = 0; i < 10; i++) step(1'b0, (i == 4), 32'h3C3C3C3C, 8'hF0);
    run(2 * FRAME);

    // leading-zero candidates
    step(1'b1, 1'b1, 32'h00000A00, 8'hFF);
    run(2 * FRAME);
    step(1'b1, 1'b1, 32'h00000000, 8'h00);
    run(2 * FRAME);

    // async reset mid-scan with a load still pending
    run_to(9);
    step(1'b1, 1'b1, 32'h55555555, 8'hAA);
    run(3);
    async_reset();
    run(FRAME + 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
